// File: rtl/rr_mux2_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rr_mux2_arbiter
// Description : Round-robin arbiter feeding the 2:1 data mux. It accepts
//               two valid/ready streams (A, B), grants at most one transfer
//               per cycle and presents the winning word on a registered
//               valid/ready output, together with the select `s` that
//               produced it (0 = A, 1 = B).
//
// Parameters  : WIDTH  - data width of a_data, b_data, y_data
//               CNT_W  - width of the optional grant counters
//
// Ports       : clk, rst_n               clock / async active-low reset
//               a_valid, a_data, a_ready source A stream
//               b_valid, b_data, b_ready source B stream
//               y_valid, y_data, y_ready output stream
//               s                        select of the word in y_data
//               cnt_a, cnt_b             saturating grant counters
//
// Optional    : RR_MUX2_ARBITER_CNT_EN - when defined, cnt_a/cnt_b count
//               grants and saturate at all-ones; when undefined they are
//               tied to zero and no counter flops exist. Ports are the same
//               in both builds.
//
// Revision    : 1.0 - initial release
// ============================================================================
module rr_mux2_arbiter #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             a_valid,
  input  logic [WIDTH-1:0] a_data,
  output logic             a_ready,
  input  logic             b_valid,
  input  logic [WIDTH-1:0] b_data,
  output logic             b_ready,
  output logic             y_valid,
  output logic [WIDTH-1:0] y_data,
  input  logic             y_ready,
  output logic             s,
  output logic [CNT_W-1:0] cnt_a,
  output logic [CNT_W-1:0] cnt_b
);

  // Which source wins when both request in the same cycle.
  typedef enum logic [0:0] {
    PRI_A = 1'b0,
    PRI_B = 1'b1
  } state_t;

  state_t             state_q;
  logic               y_valid_q;
  logic [WIDTH-1:0]   y_data_q;
  logic               s_q;

  logic               w_out_free;
  logic               w_a_xfer;
  logic               w_b_xfer;

  // The output register can take a new word if it is empty or being drained
  // this cycle; this lets a drain and a load coincide without a bubble.
  assign w_out_free = !y_valid_q || y_ready;

  // Readies never look at the requester's own valid, only at the competitor,
  // so at most one of them is high whenever both sources request.
  assign a_ready  = w_out_free && ((state_q == PRI_A) || !b_valid);
  assign b_ready  = w_out_free && ((state_q == PRI_B) || !a_valid);

  assign w_a_xfer = a_valid && a_ready;
  assign w_b_xfer = b_valid && b_ready;

  // Arbitration state and registered output stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= PRI_A;
      y_valid_q <= 1'b0;
      y_data_q  <= '0;
      s_q       <= 1'b0;
    end else if (w_a_xfer) begin
      y_data_q  <= a_data;
      y_valid_q <= 1'b1;
      s_q       <= 1'b0;
      state_q   <= PRI_B;
    end else if (w_b_xfer) begin
      y_data_q  <= b_data;
      y_valid_q <= 1'b1;
      s_q       <= 1'b1;
      state_q   <= PRI_A;
    end else if (w_out_free) begin
      // Drained with nothing to replace it: data and select keep their last
      // value so the output bus does not toggle needlessly.
      y_valid_q <= 1'b0;
    end
  end

  assign y_valid = y_valid_q;
  assign y_data  = y_data_q;
  assign s       = s_q;

`ifdef RR_MUX2_ARBITER_CNT_EN
  localparam logic [CNT_W-1:0] c_cnt_one = 1;

  logic [CNT_W-1:0] cnt_a_q;
  logic [CNT_W-1:0] cnt_b_q;

  // Grant counters stop at all-ones instead of wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_a_q <= '0;
      cnt_b_q <= '0;
    end else begin
      if (w_a_xfer && (cnt_a_q != '1)) begin
        cnt_a_q <= cnt_a_q + c_cnt_one;
      end
      if (w_b_xfer && (cnt_b_q != '1)) begin
        cnt_b_q <= cnt_b_q + c_cnt_one;
      end
    end
  end

  assign cnt_a = cnt_a_q;
  assign cnt_b = cnt_b_q;
`else
  assign cnt_a = '0;
  assign cnt_b = '0;
`endif

endmodule
`default_nettype wire
